// File: rtl/fetch_stage.sv
// fetch_stage: MIPS32 instruction fetch stage and IF/ID pipeline register.
// Owns the PC, fetches from instruction memory over a req/ack handshake and
// presents the fetched instruction (plus PC+4) to decode. Handles stalls,
// flushes and branch/jump redirects, including redirects during a wait.
//
// Memory handshake: imem_req is a registered-state (Moore) request that stays
// high, with imem_addr stable, until the first cycle imem_ack is sampled high;
// the word on imem_data is consumed on that clock edge. Only one request is
// ever outstanding, and the PC never moves while it is outstanding.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic [DATA_WIDTH-1:0] if_id_instr,
    output logic [DATA_WIDTH-1:0] if_id_pc4,
    output logic                  if_id_valid,
    output logic [5:0]            opcode,
    output logic [5:0]            funct,
    output logic                  fetch_busy,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  redir_pend_q, redir_pend_d;
    logic [DATA_WIDTH-1:0] redir_pc_q, redir_pc_d;
    logic [DATA_WIDTH-1:0] pend_q, pend_d;
    ifid_op_t              ifid_op;
    logic [DATA_WIDTH-1:0] load_instr;
    logic [DATA_WIDTH-1:0] pc_plus4;

    // PC+4 wraps naturally at the 32-bit boundary
    assign pc_plus4 = pc_q + DATA_WIDTH'(4);

    // Moore-style memory interface and decode taps
    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign fetch_busy = (state_q == S_FETCH) && !imem_ack;
    assign opcode     = if_id_instr[31:26];
    assign funct      = if_id_instr[5:0];
    assign fsm_state  = state_q;

    // Next-state, PC and IF/ID action selection
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_pc_d   = redir_pc_q;
        pend_d       = pend_q;
        load_instr   = imem_data;
        // Stalled decode holds its instruction; otherwise it sees a bubble
        // unless a real instruction is delivered below.
        ifid_op      = stall ? IFID_HOLD : IFID_BUBBLE;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (redirect || redir_pend_q) begin
                        // Wrong-path word: drop it, live redirect beats stored one
                        pc_d         = redirect ? redirect_pc : redir_pc_q;
                        redir_pend_d = 1'b0;
                    end else if (stall) begin
                        // Park the word until decode can take it
                        pend_d  = imem_data;
                        state_d = S_HOLD;
                    end else begin
                        ifid_op = IFID_LOAD;
                        pc_d    = pc_plus4;
                    end
                end else if (redirect) begin
                    // Address must stay put until ack; remember where to go
                    redir_pend_d = 1'b1;
                    redir_pc_d   = redirect_pc;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pend_d  = '0;
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (!stall) begin
                    load_instr = pend_q;
                    ifid_op    = IFID_LOAD;
                    pc_d       = pc_plus4;
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush always wins over hold and new data
        if (flush) begin
            ifid_op = IFID_BUBBLE;
        end
    end

    // Fetch-side state: FSM, PC, stored redirect and parked word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= PC_RESET;
            redir_pend_q <= 1'b0;
            redir_pc_q   <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pend_q <= redir_pend_d;
            redir_pc_q   <= redir_pc_d;
            pend_q       <= pend_d;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_id_instr <= '0;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
        end else begin
            unique case (ifid_op)
                IFID_LOAD: begin
                    if_id_instr <= load_instr;
                    if_id_pc4   <= pc_plus4;
                    if_id_valid <= 1'b1;
                end
                IFID_BUBBLE: begin
                    if_id_instr <= '0;
                    if_id_pc4   <= '0;
                    if_id_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed, table-driven bench for fetch_stage.
// Each table row is one clock cycle: inputs applied just after the falling
// edge, outputs compared 1 ns later (well before the next rising edge).
module tb_fetch_stage;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic        clk;
    logic        rst_n;
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;

    logic        req,   w_req;
    logic [31:0] addr,  w_addr;
    logic [31:0] instr, w_instr;
    logic [31:0] pc4,   w_pc4;
    logic        valid, w_valid;
    logic [5:0]  opc,   w_opc;
    logic [5:0]  fn,    w_fn;
    logic        busy,  w_busy;
    logic [1:0]  st,    w_st;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.DATA_WIDTH(32), .PC_RESET(32'h0000_0000)) dut (
        .clock(clk), .reset(rst_n),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_data(data),
        .stall(stall), .flush(flush), .redirect(redir), .redirect_pc(rpc),
        .if_id_instr(instr), .if_id_pc4(pc4), .if_id_valid(valid),
        .opcode(opc), .funct(fn), .fetch_busy(busy), .fsm_state(st)
    );

    fetch_stage #(.DATA_WIDTH(32), .PC_RESET(32'hFFFF_FFFC)) dut_wrap (
        .clock(clk), .reset(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(ack), .imem_data(data),
        .stall(stall), .flush(flush), .redirect(redir), .redirect_pc(rpc),
        .if_id_instr(w_instr), .if_id_pc4(w_pc4), .if_id_valid(w_valid),
        .opcode(w_opc), .funct(w_fn), .fetch_busy(w_busy), .fsm_state(w_st)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic        busy;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic a, input logic [31:0] d, input logic s, input logic f,
        input logic r, input logic [31:0] rp,
        input logic e_req, input logic [31:0] e_addr, input logic e_busy,
        input logic e_valid, input logic [31:0] e_instr, input logic [31:0] e_pc4,
        input logic [1:0] e_st);
        vec_t v;
        v.ack = a; v.data = d; v.stall = s; v.flush = f; v.redir = r; v.rpc = rp;
        v.req = e_req; v.addr = e_addr; v.busy = e_busy; v.valid = e_valid;
        v.instr = e_instr; v.pc4 = e_pc4; v.st = e_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ack = 1'b0; data = '0; stall = 1'b0; flush = 1'b0; redir = 1'b0; rpc = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"},   {31'd0, req},   32'd0);
        check({tag, " addr"},  addr,           32'd0);
        check({tag, " instr"}, instr,          32'd0);
        check({tag, " pc4"},   pc4,            32'd0);
        check({tag, " valid"}, {31'd0, valid}, 32'd0);
        check({tag, " opc"},   {26'd0, opc},   32'd0);
        check({tag, " funct"}, {26'd0, fn},    32'd0);
        check({tag, " busy"},  {31'd0, busy},  32'd0);
        check({tag, " state"}, {30'd0, st},    {30'd0, ST_IDLE});
        check({tag, " w_addr"},  w_addr,           32'hFFFF_FFFC);
        check({tag, " w_instr"}, w_instr,          32'd0);
        check({tag, " w_valid"}, {31'd0, w_valid}, 32'd0);
        check({tag, " w_req"},   {31'd0, w_req},   32'd0);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] ei;
        string       tag;

        // Per-cycle vectors: ack data stall flush redir rpc | req addr busy valid instr pc4 state
        // Sequential zero-wait fetch
        tbl.push_back(mk(0, 32'h0,        0,0,0,32'h0,  0,32'h00,0, 0,32'h0,        32'h00, ST_IDLE));
        tbl.push_back(mk(1, 32'h20080005, 0,0,0,32'h0,  1,32'h00,0, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(1, 32'h00000008, 0,0,0,32'h0,  1,32'h04,0, 1,32'h20080005, 32'h04, ST_FETCH));
        tbl.push_back(mk(1, 32'h01095020, 0,0,0,32'h0,  1,32'h08,0, 1,32'h00000008, 32'h08, ST_FETCH));
        tbl.push_back(mk(1, 32'h8C0A0004, 0,0,0,32'h0,  1,32'h0C,0, 1,32'h01095020, 32'h0C, ST_FETCH));
        // Two wait states at 0x10
        tbl.push_back(mk(0, 32'h0,        0,0,0,32'h0,  1,32'h10,1, 1,32'h8C0A0004, 32'h10, ST_FETCH));
        tbl.push_back(mk(0, 32'h0,        0,0,0,32'h0,  1,32'h10,1, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(1, 32'hAC0B0008, 0,0,0,32'h0,  1,32'h10,0, 0,32'h0,        32'h00, ST_FETCH));
        // Stall on the ack edge, held three cycles
        tbl.push_back(mk(1, 32'h3C0C1234, 1,0,0,32'h0,  1,32'h14,0, 1,32'hAC0B0008, 32'h14, ST_FETCH));
        tbl.push_back(mk(0, 32'h0,        1,0,0,32'h0,  0,32'h14,0, 1,32'hAC0B0008, 32'h14, ST_HOLD));
        tbl.push_back(mk(0, 32'h0,        1,0,0,32'h0,  0,32'h14,0, 1,32'hAC0B0008, 32'h14, ST_HOLD));
        tbl.push_back(mk(0, 32'h0,        0,0,0,32'h0,  0,32'h14,0, 1,32'hAC0B0008, 32'h14, ST_HOLD));
        // Redirect + flush on an ack edge
        tbl.push_back(mk(1, 32'h12345678, 0,1,1,32'h40, 1,32'h18,0, 1,32'h3C0C1234, 32'h18, ST_FETCH));
        // Redirect during a wait, ack two cycles later
        tbl.push_back(mk(0, 32'h0,        0,0,1,32'h80, 1,32'h40,1, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(0, 32'h0,        0,0,0,32'h0,  1,32'h40,1, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(1, 32'hDEADBEEF, 0,0,0,32'h0,  1,32'h40,0, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(1, 32'h20090007, 0,0,0,32'h0,  1,32'h80,0, 0,32'h0,        32'h00, ST_FETCH));
        // Flush overrides stall
        tbl.push_back(mk(0, 32'h0,        1,1,0,32'h0,  1,32'h84,1, 1,32'h20090007, 32'h84, ST_FETCH));
        // Stall into HOLD, then redirect while still stalled
        tbl.push_back(mk(1, 32'h11112222, 1,0,0,32'h0,  1,32'h84,0, 0,32'h0,        32'h00, ST_FETCH));
        tbl.push_back(mk(0, 32'h0,        1,0,1,32'h100,0,32'h84,0, 0,32'h0,        32'h00, ST_HOLD));
        tbl.push_back(mk(1, 32'h22223333, 0,0,0,32'h0,  1,32'h100,0,0,32'h0,        32'h00, ST_FETCH));
        // Enter HOLD with a valid instruction in IF/ID
        tbl.push_back(mk(1, 32'h33334444, 1,0,0,32'h0,  1,32'h104,0,1,32'h22223333, 32'h104,ST_FETCH));
        tbl.push_back(mk(0, 32'h0,        1,0,0,32'h0,  0,32'h104,0,1,32'h22223333, 32'h104,ST_HOLD));

        // Reset state
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            ack = v.ack; data = v.data; stall = v.stall; flush = v.flush;
            redir = v.redir; rpc = v.rpc;
            #1;
            ei = v.instr;
            tag = $sformatf("row%0d", i);
            check({tag, " req"},   {31'd0, req},   {31'd0, v.req});
            check({tag, " addr"},  addr,           v.addr);
            check({tag, " busy"},  {31'd0, busy},  {31'd0, v.busy});
            check({tag, " valid"}, {31'd0, valid}, {31'd0, v.valid});
            check({tag, " instr"}, instr,          v.instr);
            check({tag, " pc4"},   pc4,            v.pc4);
            check({tag, " opc"},   {26'd0, opc},   {26'd0, ei[31:26]});
            check({tag, " funct"}, {26'd0, fn},    {26'd0, ei[5:0]});
            check({tag, " state"}, {30'd0, st},    {30'd0, v.st});
            @(negedge clk);
        end

        // Reset asserted while in HOLD: outputs clear without a clock edge
        check("pre-reset state", {30'd0, st}, {30'd0, ST_HOLD});
        rst_n = 1'b0;
        #1;
        check_all_zero("async reset");

        // Release and refetch; the wrap instance starts at 0xFFFFFFFC
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        #1;
        check("post-reset state", {30'd0, st}, {30'd0, ST_IDLE});
        @(negedge clk);
        ack = 1'b1; data = 32'h0000000C;
        #1;
        check("refetch req",  {31'd0, req},   32'd1);
        check("refetch addr", addr,           32'h0);
        check("wrap req",     {31'd0, w_req}, 32'd1);
        check("wrap addr",    w_addr,         32'hFFFF_FFFC);
        @(negedge clk);
        ack = 1'b0; data = '0;
        #1;
        check("refetch instr", instr,            32'h0000000C);
        check("refetch pc4",   pc4,              32'h4);
        check("refetch next",  addr,             32'h4);
        check("wrap valid",    {31'd0, w_valid}, 32'd1);
        check("wrap instr",    w_instr,          32'h0000000C);
        check("wrap pc4",      w_pc4,            32'h0);
        check("wrap next",     w_addr,           32'h0);
        check("wrap funct",    {26'd0, w_fn},    32'h0C);
        check("wrap busy",     {31'd0, w_busy},  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage and IF/ID pipeline register of the MIPS32 core. It owns the PC and talks to instruction memory with a req/ack handshake. It holds the fetched instruction in the IF/ID register and drives `opcode`/`funct` straight into `unitControl`. It handles hazard-unit stalls, pipeline flushes and branch/jump redirects, including redirects that arrive while a memory access is outstanding.

## Interface
- `PC_RESET`, 32'h0000_0000, PC value loaded on reset.
- `DATA_WIDTH`, 32, instruction/address width; the block is fixed at 32.
- `clock` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address, always equal to the PC.
- `imem_ack` in 1: `imem_data` valid this cycle; may be high in the same cycle `imem_req` rises.
- `imem_data` in 32: instruction word.
- `stall` in 1: hold the IF/ID register and block PC advance.
- `flush` in 1: overwrite the IF/ID register with a bubble.
- `redirect` in 1: branch/jump taken; the next fetch is from `redirect_pc`.
- `redirect_pc` in 32: redirect target, word-aligned.
- `if_id_instr` out 32: registered instruction; bubble = 32'h0.
- `if_id_pc4` out 32: registered PC+4 of `if_id_instr`.
- `if_id_valid` out 1: `if_id_instr` is a real instruction.
- `opcode` out 6: `if_id_instr[31:26]`, combinational.
- `funct` out 6: `if_id_instr[5:0]`, combinational.
- `fetch_busy` out 1: high in FETCH while no ack has arrived yet.

## Operation
- **State machine: IDLE, FETCH, HOLD.** Reset enters IDLE.
  - IDLE always moves to FETCH on the next edge.
  - `imem_req` = (state==FETCH). The output is Moore-style; it never depends combinationally on `redirect` or `stall`.
- **Handshake rules**
  - `imem_addr` = PC and stays stable from the cycle `imem_req` rises until the cycle `imem_ack` is sampled high.
  - The PC never changes while a request is outstanding.
  - Only one request is outstanding at a time.
- **FETCH, edge with `imem_ack`=1**
  - If `redirect` is high or `redir_pend` is set: discard the data, set PC to the target (`redirect_pc` has priority over the stored target), clear `redir_pend`, stay in FETCH.
  - Else if `stall`: latch `imem_data` into the pending register, go to HOLD. PC is unchanged.
  - Else: load IF/ID with (`imem_data`, PC+4, valid=1), set PC to PC+4, stay in FETCH.
- **FETCH, edge with `imem_ack`=0**
  - If `redirect`: set `redir_pend`=1 and store `redirect_pc`. The current address is held until ack, and that ack's data is discarded.
  - If not stalled: IF/ID loads a bubble (instr 0, pc4 0, valid 0).
- **HOLD**
  - `imem_req`=0.
  - On `redirect`: drop the pending word, set PC to `redirect_pc`, go to FETCH.
  - Else when `stall`=0: load IF/ID from the pending word, set PC to PC+4, go to FETCH.
- **IF/ID update priority:** `flush` > `stall` (hold) > new instruction > bubble.
  - `flush` overrides `stall`.
  - `flush` does not affect the PC or the FSM.
- **Arithmetic:** PC+4 wraps modulo 2^32. `if_id_pc4` carries the wrapped value.
- **Redirect vs. stall on the same edge:** `redirect` wins for PC and FSM. IF/ID follows the priority rule above.
- **Outputs:** `opcode` and `funct` decode only the registered IF/ID contents. A bubble yields opcode 0 / funct 0, which is `unitControl`'s NOP (sll $0).

## Timing
- **Reset** (asynchronous, immediate on `reset`=0):
  - PC=`PC_RESET`, state=IDLE, `imem_req`=0.
  - `if_id_instr`=0, `if_id_pc4`=0, `if_id_valid`=0, `opcode`=0, `funct`=0.
  - `redir_pend`=0, pending register=0, `fetch_busy`=0.
- First `imem_req` is high in the first cycle after the first edge following reset release.
- **Latency:** ack in cycle N puts the instruction in IF/ID after the edge ending cycle N.
- **Throughput:** with zero-wait memory (ack every cycle), one instruction per cycle.
- **Redirect cost:** a redirect on an ack edge issues the target address in the next cycle. A redirect during a wait costs the remaining wait plus one cycle.
- **Reset mid-operation:** all state is abandoned, including HOLD, a pending redirect and an outstanding request. Memory must tolerate a dropped request.

## Test plan
- **Reset and sequential fetch:** `PC_RESET`=0, zero-wait memory holding 0x20080005 @0 and 0x00000008 @4 → IF/ID shows 0x20080005, pc4=4, opcode=0x08, funct=0x05, then 0x00000008, opcode=0, funct=0x08. `imem_addr` steps 0,4,8.
- **Wait states:** ack delayed 2 cycles at addr 0x10 → `imem_addr` held at 0x10, two bubbles (valid 0, instr 0), then valid instruction with pc4=0x14.
- **Stall at ack:** `stall`=1 on the ack edge for 3 cycles → state HOLD, `imem_req`=0, IF/ID unchanged. After release the pending word appears in IF/ID and `imem_addr` moves to PC+4.
- **Redirect + flush on ack edge:** `redirect_pc`=0x40 → fetched data discarded, IF/ID becomes bubble, next `imem_addr`=0x40.
- **Redirect during wait:** redirect to 0x80 two cycles before ack → address unchanged until ack, ack data discarded, next `imem_addr`=0x80.
- **Reset and wrap:** reset asserted in HOLD → all outputs 0 immediately. Separately, `PC_RESET`=0xFFFFFFFC → pc4=0, next `imem_addr`=0.
